// File: rtl/grs_miner_scheduler.sv
// grs_miner_scheduler: work fan-out, miner reset/fill/drain sequencing and
// round-robin capture of per-core finds into a result FIFO.
// Optional feature: define GRS_SCHED_STATS_EN to build the hash_count counter;
// otherwise hash_count reads as zero.
//
// state | meaning
// IDLE  | no work since reset
// LOAD  | miners held in reset while new work settles (2 cycles)
// FILL  | miner pipelines filling, finds masked (OFFSET+2 cycles)
// SCAN  | sweep counter running, finds captured
// DRAIN | sweep covered, in-flight finds still captured (OFFSET+2 cycles)
// DONE  | sweep complete, waiting for new work
module grs_miner_scheduler #(
  parameter int          CORES        = 1,
  parameter int          OFFSET       = 172,
  parameter logic [32:0] SWEEP_CYCLES = 33'(33'h1_0000_0000 / CORES),
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 work_valid,
  output logic                 work_ready,
  input  logic [639:0]         work_block,
  input  logic [31:0]          work_nonce,
  output logic                 miner_reset,
  output logic [639:0]         miner_block,
  output logic [CORES*32-1:0]  miner_nonce_start,
  input  logic [CORES-1:0]     miner_found,
  input  logic [CORES*32-1:0]  miner_nonce,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [31:0]          result_nonce,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [47:0]          hash_count
);

  localparam int RW = (CORES > 1) ? $clog2(CORES) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_FILL, ST_SCAN, ST_DRAIN, ST_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   tmr;
  logic [32:0]   sweep_cnt;
  logic          accept;
  logic          sweep_end;
  logic          cap_en;

  logic [CORES-1:0] pend_v;
  logic [31:0]      pend_n [CORES];
  logic [RW-1:0]    rr;
  logic [CORES-1:0] gnt;
  logic [RW-1:0]    gnt_idx;
  logic [RW-1:0]    scan_idx;
  logic             gnt_any;
  int               rr_sum;

  logic [31:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    fifo_cnt, fifo_cnt_nxt;
  logic             fifo_full;
  logic             pop;
  logic             push_ok;

  assign accept    = work_valid && work_ready;
  assign sweep_end = (sweep_cnt + 33'd1 == SWEEP_CYCLES);
  assign cap_en    = (state == ST_SCAN) || (state == ST_DRAIN);
  assign fifo_full = (fifo_cnt == CW'(FIFO_DEPTH));
  assign pop       = result_valid && result_ready;
  // A pop frees the head in the same cycle, so a full FIFO still accepts.
  assign push_ok   = !fifo_full || pop;
  assign result_nonce = fifo_mem[rd_ptr];

  // Next-state decode; new work preempts from any state that offers ready.
  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = ST_LOAD;
    end else begin
      case (state)
        ST_LOAD:  if (tmr == '0) state_nxt = ST_FILL;
        ST_FILL:  if (tmr == '0) state_nxt = ST_SCAN;
        ST_SCAN:  if (sweep_end) state_nxt = ST_DRAIN;
        ST_DRAIN: if (tmr == '0) state_nxt = ST_DONE;
        default:  ;
      endcase
    end
  end

  // State register, phase down-counter, sweep counter and registered status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      tmr         <= '0;
      sweep_cnt   <= '0;
      miner_reset <= 1'b1;
      work_ready  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      miner_reset <= (state_nxt == ST_LOAD);
      work_ready  <= state_nxt inside {ST_IDLE, ST_SCAN, ST_DRAIN, ST_DONE};
      busy        <= state_nxt inside {ST_LOAD, ST_FILL, ST_SCAN, ST_DRAIN};
      done        <= (state_nxt == ST_DONE);
      if (accept)
        tmr <= 32'd1;
      else if (state_nxt != state)
        tmr <= 32'(OFFSET + 1);
      else if (tmr != '0)
        tmr <= tmr - 32'd1;
      if (accept)
        sweep_cnt <= '0;
      else if (state == ST_SCAN)
        sweep_cnt <= sweep_cnt + 33'd1;
    end
  end

  // Latch the accepted header and per-lane start nonces.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      miner_block       <= '0;
      miner_nonce_start <= '0;
    end else if (accept) begin
      miner_block <= work_block;
      for (int k = 0; k < CORES; k++)
        miner_nonce_start[k*32 +: 32] <= work_nonce + 32'(k);
    end
  end

  // Round-robin pick: first pending slot at or after the pointer.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    rr_sum   = 0;
    scan_idx = '0;
    if (push_ok) begin
      for (int i = 0; i < CORES; i++) begin
        rr_sum = int'(rr) + i;
        if (rr_sum >= CORES) rr_sum = rr_sum - CORES;
        scan_idx = RW'(rr_sum);
        if (!gnt_any && pend_v[scan_idx]) begin
          gnt_any       = 1'b1;
          gnt_idx       = scan_idx;
          gnt[scan_idx] = 1'b1;
        end
      end
    end
  end

  // Per-core pending slots, sticky overflow and arbiter pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_v   <= '0;
      overflow <= 1'b0;
      rr       <= '0;
      for (int k = 0; k < CORES; k++) pend_n[k] <= '0;
    end else begin
      for (int k = 0; k < CORES; k++) begin
        if (cap_en && miner_found[k]) begin
          if (pend_v[k] && !gnt[k]) begin
            overflow <= 1'b1;
          end else begin
            pend_v[k] <= 1'b1;
            pend_n[k] <= miner_nonce[k*32 +: 32];
          end
        end else if (gnt[k]) begin
          pend_v[k] <= 1'b0;
        end
      end
      if (gnt_any)
        rr <= (gnt_idx == RW'(CORES - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    fifo_cnt_nxt = fifo_cnt;
    if (gnt_any && !pop)
      fifo_cnt_nxt = fifo_cnt + 1'b1;
    else if (!gnt_any && pop)
      fifo_cnt_nxt = fifo_cnt - 1'b1;
  end

  // Result FIFO storage and pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      result_valid <= 1'b0;
      for (int d = 0; d < FIFO_DEPTH; d++) fifo_mem[d] <= '0;
    end else begin
      if (gnt_any) begin
        fifo_mem[wr_ptr] <= pend_n[gnt_idx];
        wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      fifo_cnt     <= fifo_cnt_nxt;
      result_valid <= (fifo_cnt_nxt != '0);
    end
  end

`ifdef GRS_SCHED_STATS_EN
  logic [48:0] hash_sum;
  assign hash_sum = {1'b0, hash_count} + 49'(CORES);

  // Saturating count of nonces tried during SCAN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      hash_count <= '0;
    else if (state == ST_SCAN)
      hash_count <= hash_sum[48] ? '1 : hash_sum[47:0];
  end
`else
  assign hash_count = '0;
`endif

endmodule
